hd_input_frame_buffer: RTL

- Multi-channel input front-end between the preprocessing input stage and the uCode sequencer of the HD accelerator.
- Runs the sample handshake (valid / ack_sample / switch_channel) over NUM_CHANNELS round-robin channels and assembles one sample per channel into a frame.
- Buffers up to NUM_FRAMES complete frames in a FIFO and gives the sequencer random per-channel read access to the oldest frame.
- Overflow handling is selectable: stall the input stage, or drop new frames.

---
 rtl/hd_input_frame_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hd_input_frame_buffer.sv
// Round-robin sample capture into a NUM_FRAMES frame FIFO with random per-channel reads of the head frame.
// Latency: valid->ack 1 cycle, ack->switch 1 cycle; full FIFO either stalls acks or acks and discards new frames.
module hd_input_frame_buffer #(
  parameter int NUM_CHANNELS  = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_FRAMES    = 2,
  parameter int OVERFLOW_MODE = 0,
  parameter int CH_IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int CNT_WIDTH     = $clog2(NUM_FRAMES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    idata_valid_i,
  input  logic [DATA_WIDTH-1:0]   idata_i,
  output logic                    idata_ack_sample_o,
  output logic                    idata_switch_channel_o,
  output logic [CH_IDX_WIDTH-1:0] cur_channel_o,
  output logic                    frame_valid_o,
  input  logic [CH_IDX_WIDTH-1:0] rd_ch_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    frame_pop_i,
  output logic [CNT_WIDTH-1:0]    frame_count_o,
  output logic                    overflow_o,
  output logic [15:0]             dropped_cnt_o
);

  localparam int PTR_WIDTH = $clog2(NUM_FRAMES);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ACK, S_SWITCH, S_FULL} state_t;

  state_t                  state_q, state_d;
  logic [CH_IDX_WIDTH-1:0] channel_q, channel_d;
  logic                    discard_q, discard_d;
  logic [PTR_WIDTH-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]    count_q, count_post;
  logic                    overflow_q;
  logic [15:0]             dropped_q;
  logic [DATA_WIDTH-1:0]   storage [NUM_FRAMES][NUM_CHANNELS];

  logic last_ch, boundary, commit, drop, pop_fire, full, full_post;

  assign last_ch   = (int'(channel_q) == NUM_CHANNELS - 1);
  assign boundary  = (state_q == S_SWITCH) && last_ch;
  assign commit    = boundary && !discard_q;
  assign drop      = boundary && discard_q;
  assign pop_fire  = frame_pop_i && (count_q != '0);
  assign full      = (count_q == CNT_WIDTH'(NUM_FRAMES));
  assign full_post = (count_post == CNT_WIDTH'(NUM_FRAMES));

  // Occupancy after this cycle's commit/pop, used for the next-frame decision.
  always_comb begin
    count_post = count_q;
    if (commit && !pop_fire)      count_post = count_q + CNT_WIDTH'(1);
    else if (!commit && pop_fire) count_post = count_q - CNT_WIDTH'(1);
  end

  always_comb begin
    state_d   = state_q;
    channel_d = channel_q;
    discard_d = discard_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          if (!full) begin
            state_d   = S_CAPTURE;
            discard_d = 1'b0;
          end else if (OVERFLOW_MODE == 0) begin
            state_d = S_FULL;
          end else begin
            state_d   = S_CAPTURE;
            discard_d = 1'b1;
          end
        end
      end
      S_CAPTURE: if (idata_valid_i) state_d = S_ACK;
      S_ACK:     state_d = S_SWITCH;
      S_SWITCH: begin
        if (!last_ch) begin
          channel_d = channel_q + CH_IDX_WIDTH'(1);
          state_d   = S_CAPTURE;
        end else begin
          channel_d = '0;
          discard_d = 1'b0;
          if (!en_i) begin
            state_d = S_IDLE;
          end else if (full_post) begin
            if (OVERFLOW_MODE == 0) begin
              state_d = S_FULL;
            end else begin
              state_d   = S_CAPTURE;
              discard_d = 1'b1;
            end
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_FULL:  if (pop_fire) state_d = en_i ? S_CAPTURE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= S_IDLE;
      channel_q  <= '0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      discard_q <= discard_d;
      count_q   <= count_post;
      if (commit)   wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (pop_fire) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  // Sample storage carries no reset; only committed frames are ever read.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && state_q == S_CAPTURE && idata_valid_i && !discard_q)
      storage[wr_ptr_q][channel_q] <= idata_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (int'(rd_ch_idx_i) < NUM_CHANNELS) rd_data_o = storage[rd_ptr_q][rd_ch_idx_i];
  end

  assign idata_ack_sample_o     = (state_q == S_ACK);
  assign idata_switch_channel_o = (state_q == S_SWITCH);
  assign cur_channel_o          = channel_q;
  assign frame_valid_o          = (count_q != '0);
  assign frame_count_o          = count_q;
  assign overflow_o             = overflow_q;
  assign dropped_cnt_o          = dropped_q;

endmodule
